// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control sequencer.
// Optional feature macro: MC_ILLEGAL_TRAP_EN (adds TRAP state and illegal_op).
package mc_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned SEL_W    = 2;

  // Sequencer states; encodings are visible on state_dbg
  typedef enum logic [STATE_W-1:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_R_WB     = 4'd7,
    ST_EXEC_I   = 4'd8,
    ST_I_WB     = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    ST_TRAP     = 4'd12
`endif
  } state_e;

  // Supported opcodes (IR[31:26])
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  // ALU operation selects
  localparam logic [SEL_W-1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [SEL_W-1:0] ALU_OP_IMM   = 2'b11;

  // ALU B operand selects
  localparam logic [SEL_W-1:0] SRC_B_REG     = 2'b00;
  localparam logic [SEL_W-1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [SEL_W-1:0] SRC_B_IMM     = 2'b10;
  localparam logic [SEL_W-1:0] SRC_B_IMM_SH2 = 2'b11;

  // Next-PC source selects
  localparam logic [SEL_W-1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'b10;

  // Datapath control word
  typedef struct packed {
    logic             pc_write;
    logic             pc_write_cond;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] alu_op;
    logic [SEL_W-1:0] pc_source;
    logic             instr_done;
  } ctrl_t;

  // Instruction class flags produced by the opcode decoder
  typedef struct packed {
    logic r_type;
    logic mem;
    logic load;
    logic imm_alu;
    logic branch;
    logic jump;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/mc_opcode_class.sv
// Combinational opcode-to-instruction-class decode.
module mc_opcode_class
  import mc_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_t           op_class_c
);

  // Map each supported opcode to exactly one class; everything else is illegal
  always_comb begin
    op_class_c = '0;
    case (opcode)
      OP_RTYPE: op_class_c.r_type = 1'b1;
      OP_LW: begin
        op_class_c.mem  = 1'b1;
        op_class_c.load = 1'b1;
      end
      OP_SW:    op_class_c.mem = 1'b1;
      OP_ADDI,
      OP_ANDI,
      OP_ORI,
      OP_SLTI:  op_class_c.imm_alu = 1'b1;
      OP_BEQ:   op_class_c.branch  = 1'b1;
      OP_J:     op_class_c.jump    = 1'b1;
      default:  op_class_c.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer: state register, next-state logic,
// registered Moore control word plus mem_ready-gated handshake terms.
// Optional feature macro: MC_ILLEGAL_TRAP_EN (unknown opcodes trap and set
// sticky illegal_op; otherwise they retire silently as a NOP).
module multicycle_control
  import mc_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [SEL_W-1:0]    alu_src_b,
  output logic [SEL_W-1:0]    alu_op,
  output logic [SEL_W-1:0]    pc_source,
  output logic                instr_done,
  output logic [STATE_W-1:0]  state_dbg
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic                illegal_op
`endif
);

  state_e    state_q;
  state_e    state_next_c;
  ctrl_t     ctrl_q;
  op_class_t op_class_c;
  logic      imm_add_c;
  logic      fetch_go_c;
  logic      wr_done_c;
`ifdef MC_ILLEGAL_TRAP_EN
  logic      illegal_q;
`endif

  mc_opcode_class u_opcode_class (
    .opcode     (opcode),
    .op_class_c (op_class_c)
  );

  assign imm_add_c = (opcode == OP_ADDI);

  // Moore control word for a state; the word is registered on entry to it
  function automatic ctrl_t moore_decode(input state_e s, input logic imm_add);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.mem_read  = 1'b1;
        c.i_or_d    = 1'b0;
        c.alu_src_a = 1'b0;
        c.alu_src_b = SRC_B_FOUR;
        c.alu_op    = ALU_OP_ADD;
        c.pc_source = PC_SRC_ALU;
      end
      ST_DECODE: begin
        c.alu_src_a = 1'b0;
        c.alu_src_b = SRC_B_IMM_SH2;
        c.alu_op    = ALU_OP_ADD;
      end
      ST_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = ALU_OP_ADD;
      end
      ST_MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_dst    = 1'b0;
        c.instr_done = 1'b1;
      end
      ST_MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      ST_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRC_B_REG;
        c.alu_op    = ALU_OP_FUNCT;
      end
      ST_R_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.mem_to_reg = 1'b0;
        c.instr_done = 1'b1;
      end
      ST_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = imm_add ? ALU_OP_ADD : ALU_OP_IMM;
      end
      ST_I_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b0;
        c.mem_to_reg = 1'b0;
        c.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRC_B_REG;
        c.alu_op        = ALU_OP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PC_SRC_ALUOUT;
        c.instr_done    = 1'b1;
      end
      ST_JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_source  = PC_SRC_JUMP;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state selection; memory states hold until mem_ready
  always_comb begin
    state_next_c = state_q;
    case (state_q)
      ST_FETCH:    if (mem_ready) state_next_c = ST_DECODE;
      ST_DECODE: begin
        state_next_c = ST_FETCH;
        if (op_class_c.r_type)       state_next_c = ST_EXEC_R;
        else if (op_class_c.mem)     state_next_c = ST_MEM_ADDR;
        else if (op_class_c.imm_alu) state_next_c = ST_EXEC_I;
        else if (op_class_c.branch)  state_next_c = ST_BRANCH;
        else if (op_class_c.jump)    state_next_c = ST_JUMP;
        else if (op_class_c.illegal) begin
`ifdef MC_ILLEGAL_TRAP_EN
          state_next_c = ST_TRAP;
`else
          state_next_c = ST_FETCH;
`endif
        end
      end
      ST_MEM_ADDR: state_next_c = op_class_c.load ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   if (mem_ready) state_next_c = ST_MEM_WB;
      ST_MEM_WB:   state_next_c = ST_FETCH;
      ST_MEM_WR:   if (mem_ready) state_next_c = ST_FETCH;
      ST_EXEC_R:   state_next_c = ST_R_WB;
      ST_R_WB:     state_next_c = ST_FETCH;
      ST_EXEC_I:   state_next_c = ST_I_WB;
      ST_I_WB:     state_next_c = ST_FETCH;
      ST_BRANCH:   state_next_c = ST_FETCH;
      ST_JUMP:     state_next_c = ST_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
      ST_TRAP:     state_next_c = ST_TRAP;
`endif
      default:     state_next_c = ST_FETCH;
    endcase
  end

  // State register with the control word registered alongside it
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      ctrl_q    <= moore_decode(ST_FETCH, 1'b0);
`ifdef MC_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_next_c;
      ctrl_q    <= moore_decode(state_next_c, imm_add_c);
`ifdef MC_ILLEGAL_TRAP_EN
      illegal_q <= illegal_q | (state_next_c == ST_TRAP);
`endif
    end
  end

  // Handshake-completion terms that must react to mem_ready in the same cycle
  assign fetch_go_c = (state_q == ST_FETCH)  && mem_ready;
  assign wr_done_c  = (state_q == ST_MEM_WR) && mem_ready;

  // Output stage: reset forces every output low, including the gated terms
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = '0;
    alu_op        = '0;
    pc_source     = '0;
    instr_done    = 1'b0;
    state_dbg     = '0;
`ifdef MC_ILLEGAL_TRAP_EN
    illegal_op    = 1'b0;
`endif
    if (!reset) begin
      pc_write      = ctrl_q.pc_write | fetch_go_c;
      pc_write_cond = ctrl_q.pc_write_cond;
      i_or_d        = ctrl_q.i_or_d;
      mem_read      = ctrl_q.mem_read;
      mem_write     = ctrl_q.mem_write;
      ir_write      = ctrl_q.ir_write | fetch_go_c;
      reg_dst       = ctrl_q.reg_dst;
      mem_to_reg    = ctrl_q.mem_to_reg;
      reg_write     = ctrl_q.reg_write;
      alu_src_a     = ctrl_q.alu_src_a;
      alu_src_b     = ctrl_q.alu_src_b;
      alu_op        = ctrl_q.alu_op;
      pc_source     = ctrl_q.pc_source;
      instr_done    = ctrl_q.instr_done | wr_done_c;
      state_dbg     = STATE_W'(state_q);
`ifdef MC_ILLEGAL_TRAP_EN
      illegal_op    = illegal_q;
`endif
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control.
// Honours MC_ILLEGAL_TRAP_EN to match the build under test.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_dbg;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .instr_done    (instr_done),
    .state_dbg     (state_dbg)
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    .illegal_op    (illegal_op)
`endif
  );

  // Observed word: pcw pcc iod mrd mwr irw rdst m2r rw asa asb aop psrc done state
  typedef logic [20:0] obs_t;
  obs_t observed;
  assign observed = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                     pc_source, instr_done, state_dbg};

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       mr;
    obs_t       exp;
    logic       ill;
    string      name;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;
  int   done_count = 0;

  function automatic obs_t o(input logic pcw, input logic pcc, input logic iod,
                             input logic mrd, input logic mwr, input logic irw,
                             input logic rdst, input logic m2r, input logic rw,
                             input logic asa, input logic [1:0] asb,
                             input logic [1:0] aop, input logic [1:0] psrc,
                             input logic done, input logic [3:0] st);
    return {pcw, pcc, iod, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, psrc, done, st};
  endfunction

  task automatic add(input logic rst, input logic [5:0] op, input logic mr,
                     input obs_t exp, input logic ill, input string name);
    vec_t v;
    v.rst = rst; v.op = op; v.mr = mr; v.exp = exp; v.ill = ill; v.name = name;
    vq.push_back(v);
  endtask

  task automatic check_word(input string name, input int idx, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %b expected %b", name, idx, got, exp);
    end
  endtask

  obs_t RST, FW, FGO, DEC, MAD, MRD, MWB, MWRW, MWRGO, EXR, RWB, EXI_ADD, EXI_IMM, IWB, BR, JMP;
  obs_t TRP;

  initial begin
    // Hand-computed expected control words per state
    RST     = o(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,4'd0);
    FW      = o(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,4'd0);
    FGO     = o(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,4'd0);
    DEC     = o(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,4'd1);
    MAD     = o(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,4'd2);
    MRD     = o(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,4'd3);
    MWB     = o(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,4'd4);
    MWRW    = o(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,4'd5);
    MWRGO   = o(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,1,4'd5);
    EXR     = o(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,4'd6);
    RWB     = o(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,4'd7);
    EXI_ADD = o(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,4'd8);
    EXI_IMM = o(0,0,0,0,0,0,0,0,0,1,2'b10,2'b11,2'b00,0,4'd8);
    IWB     = o(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,1,4'd9);
    BR      = o(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,4'd10);
    JMP     = o(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,4'd11);
    TRP     = o(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,4'd12);

    // Reset
    add(1, 6'h00, 0, RST, 0, "reset0");
    add(1, 6'h00, 1, RST, 0, "reset1");
    // R-type
    add(0, 6'h00, 1, FGO, 0, "r_fetch");
    add(0, 6'h00, 1, DEC, 0, "r_decode");
    add(0, 6'h00, 1, EXR, 0, "r_exec");
    add(0, 6'h00, 1, RWB, 0, "r_wb");
    // LW with two read wait cycles
    add(0, 6'h23, 1, FGO, 0, "lw_fetch");
    add(0, 6'h23, 1, DEC, 0, "lw_decode");
    add(0, 6'h23, 1, MAD, 0, "lw_addr");
    add(0, 6'h23, 0, MRD, 0, "lw_rd_wait1");
    add(0, 6'h23, 0, MRD, 0, "lw_rd_wait2");
    add(0, 6'h23, 1, MRD, 0, "lw_rd_go");
    add(0, 6'h23, 1, MWB, 0, "lw_wb");
    // FETCH stall then ANDI
    add(0, 6'h0C, 0, FW,  0, "stall1");
    add(0, 6'h0C, 0, FW,  0, "stall2");
    add(0, 6'h0C, 0, FW,  0, "stall3");
    add(0, 6'h0C, 1, FGO, 0, "andi_fetch");
    add(0, 6'h0C, 1, DEC, 0, "andi_decode");
    add(0, 6'h0C, 1, EXI_IMM, 0, "andi_exec");
    add(0, 6'h0C, 1, IWB, 0, "andi_wb");
    // ADDI with mem_ready low in non-memory states
    add(0, 6'h08, 1, FGO, 0, "addi_fetch");
    add(0, 6'h08, 0, DEC, 0, "addi_decode");
    add(0, 6'h08, 0, EXI_ADD, 0, "addi_exec");
    add(0, 6'h08, 0, IWB, 0, "addi_wb");
    // BEQ
    add(0, 6'h04, 1, FGO, 0, "beq_fetch");
    add(0, 6'h04, 1, DEC, 0, "beq_decode");
    add(0, 6'h04, 1, BR,  0, "beq_branch");
    // J
    add(0, 6'h02, 1, FGO, 0, "j_fetch");
    add(0, 6'h02, 0, DEC, 0, "j_decode");
    add(0, 6'h02, 0, JMP, 0, "j_jump");
    // SW with one write wait
    add(0, 6'h2B, 1, FGO,  0, "sw_fetch");
    add(0, 6'h2B, 1, DEC,  0, "sw_decode");
    add(0, 6'h2B, 1, MAD,  0, "sw_addr");
    add(0, 6'h2B, 0, MWRW, 0, "sw_wr_wait");
    add(0, 6'h2B, 1, MWRGO, 0, "sw_wr_go");
    // SW aborted by reset while waiting in MEM_WR
    add(0, 6'h2B, 1, FGO,  0, "swa_fetch");
    add(0, 6'h2B, 1, DEC,  0, "swa_decode");
    add(0, 6'h2B, 1, MAD,  0, "swa_addr");
    add(0, 6'h2B, 0, MWRW, 0, "swa_wr_wait");
    add(1, 6'h2B, 1, RST,  0, "swa_reset");
    add(0, 6'h2B, 0, FW,   0, "swa_refetch");
    // Illegal opcode
    add(0, 6'h3F, 1, FGO,  0, "ill_fetch");
    add(0, 6'h3F, 1, DEC,  0, "ill_decode");
`ifdef MC_ILLEGAL_TRAP_EN
    add(0, 6'h3F, 1, TRP,  1, "trap1");
    add(0, 6'h3F, 0, TRP,  1, "trap2");
    add(0, 6'h00, 1, TRP,  1, "trap3");
    add(1, 6'h00, 1, RST,  0, "trap_reset");
    add(0, 6'h00, 0, FW,   0, "trap_refetch");
`else
    add(0, 6'h3F, 0, FW,   0, "nop_refetch");
    add(0, 6'h00, 0, FW,   0, "nop_hold");
`endif

    // Apply table: drive at negedge, sample 1 time unit later
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset     = vq[i].rst;
      opcode    = vq[i].op;
      mem_ready = vq[i].mr;
      #1;
      check_word(vq[i].name, i, observed, vq[i].exp);
      checks++;
      if (mem_read && mem_write) begin
        errors++;
        $display("FAIL strobe_excl (vec %0d): mem_read=%b mem_write=%b required not both 1",
                 i, mem_read, mem_write);
      end
`ifdef MC_ILLEGAL_TRAP_EN
      checks++;
      if (illegal_op !== vq[i].ill) begin
        errors++;
        $display("FAIL illegal_op %s (vec %0d): got %b expected %b",
                 vq[i].name, i, illegal_op, vq[i].ill);
      end
`endif
      if (instr_done === 1'b1) done_count++;
    end

    // Seven instructions completed in the table (aborted SW and illegal op excluded)
    checks++;
    if (done_count != 7) begin
      errors++;
      $display("FAIL instr_done_count: got %0d expected 7", done_count);
    end

    // LW latency with N read waits: expect 5+N cycles from FETCH to instr_done
    for (int n = 0; n < 4; n += ((n == 1) ? 2 : 1)) begin
      int  cyc;
      int  at;
      bit  seen;
      cyc = 0; at = -1; seen = 1'b0;
      while (!seen && cyc < 40) begin
        @(negedge clk);
        reset     = 1'b0;
        opcode    = 6'h23;
        mem_ready = (cyc >= 3 && cyc < 3 + n) ? 1'b0 : 1'b1;
        #1;
        if (cyc >= 3 && cyc < 3 + n) begin
          checks++;
          if (!(mem_read === 1'b1 && i_or_d === 1'b1 && state_dbg === 4'd3)) begin
            errors++;
            $display("FAIL lw_wait_hold n=%0d cyc=%0d: mem_read=%b i_or_d=%b state=%0d required 1 1 3",
                     n, cyc, mem_read, i_or_d, state_dbg);
          end
        end
        if (instr_done === 1'b1) begin
          seen = 1'b1;
          at   = cyc;
        end
        cyc++;
      end
      checks++;
      if (!seen || (at + 1) != 5 + n) begin
        errors++;
        $display("FAIL lw_latency n=%0d: got %0d cycles (seen=%0d) expected %0d",
                 n, at + 1, seen, 5 + n);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
